// File: rtl/regfile_mp.sv
// Multi-port CPU register file: NUM_RD registered read ports, ALU and load
// write ports with write-first bypass, a pending-load busy scoreboard, and a
// PC alias at PC_IDX (reads return pc_i, writes are dropped).
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 3,
    parameter int PC_IDX   = 15
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [DATA_W-1:0]        pc_i,
    input  logic                     wr0_en_i,
    input  logic [ADDR_W-1:0]        wr0_addr_i,
    input  logic [DATA_W-1:0]        wr0_data_i,
    input  logic                     wr1_en_i,
    input  logic [ADDR_W-1:0]        wr1_addr_i,
    input  logic [DATA_W-1:0]        wr1_data_i,
    input  logic                     busy_set_i,
    input  logic [ADDR_W-1:0]        busy_addr_i
);

    typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_arr_t;

    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

    // Power-on contents: r0=0, r1=0x8000_0000, ri=i otherwise, PC slot held 0.
    function automatic reg_arr_t init_regs();
        reg_arr_t r;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i == 0 || i == PC_IDX) begin
                r[i] = '0;
            end else if (i == 1) begin
                r[i] = DATA_W'(32'h8000_0000);
            end else begin
                r[i] = DATA_W'(i);
            end
        end
        return r;
    endfunction

    localparam reg_arr_t REG_RST = init_regs();

    reg_arr_t                  regs_q, regs_d;
    logic [NUM_REGS-1:0]       busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0]  rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]         rd_busy_q, rd_busy_d;
    logic [ADDR_W-1:0]         rd_addr [NUM_RD];

    // Next array and scoreboard state: wr0 then wr1 (wr1 wins), PC slot never
    // written; a load issue overrides a same-cycle load completion.
    always_comb begin
        regs_d = regs_q;
        if (wr0_en_i && wr0_addr_i != PC_ADDR) begin
            regs_d[wr0_addr_i] = wr0_data_i;
        end
        if (wr1_en_i && wr1_addr_i != PC_ADDR) begin
            regs_d[wr1_addr_i] = wr1_data_i;
        end
        busy_d = busy_q;
        if (wr1_en_i) begin
            busy_d[wr1_addr_i] = 1'b0;
        end
        if (busy_set_i) begin
            busy_d[busy_addr_i] = 1'b1;
        end
    end

    // Read ports see next-state array and busy bits, giving write-first bypass.
    always_comb begin
        rd_data_d = '0;
        rd_busy_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr[k] = rd_addr_i[k*ADDR_W +: ADDR_W];
            if (rd_addr[k] == PC_ADDR) begin
                rd_data_d[k*DATA_W +: DATA_W] = pc_i;
                rd_busy_d[k]                  = 1'b0;
            end else begin
                rd_data_d[k*DATA_W +: DATA_W] = regs_d[rd_addr[k]];
                rd_busy_d[k]                  = busy_d[rd_addr[k]];
            end
        end
    end

    // State and registered read outputs; reset discards any in-flight write.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            regs_q    <= REG_RST;
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            regs_q    <= regs_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_busy_o = rd_busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed cases plus random traffic, each cycle's
// expected read result pushed to a queue and checked by a separate monitor.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 4;
    localparam int RD = 3;
    localparam int PC = 15;
    localparam int EW = RD*DW + RD;

    logic              clk_i = 1'b0;
    logic              reset_ni;
    logic [RD*AW-1:0]  rd_addr_i;
    logic [RD*DW-1:0]  rd_data_o;
    logic [RD-1:0]     rd_busy_o;
    logic [DW-1:0]     pc_i;
    logic              wr0_en_i, wr1_en_i, busy_set_i;
    logic [AW-1:0]     wr0_addr_i, wr1_addr_i, busy_addr_i;
    logic [DW-1:0]     wr0_data_i, wr1_data_i;

    logic [EW-1:0]     exp_q[$];
    int                n_vec = 0;
    int                n_err = 0;

    // reference state
    logic [DW-1:0]     m_reg [NR];
    logic              m_busy [NR];

    regfile_mp dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
        .pc_i(pc_i),
        .wr0_en_i(wr0_en_i), .wr0_addr_i(wr0_addr_i), .wr0_data_i(wr0_data_i),
        .wr1_en_i(wr1_en_i), .wr1_addr_i(wr1_addr_i), .wr1_data_i(wr1_data_i),
        .busy_set_i(busy_set_i), .busy_addr_i(busy_addr_i)
    );

    // clock
    always #5 clk_i = ~clk_i;

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) begin
            if (i == 1)                 m_reg[i] = 32'h8000_0000;
            else if (i == 0 || i == PC) m_reg[i] = 32'h0;
            else                        m_reg[i] = 32'(i);
            m_busy[i] = 1'b0;
        end
    endfunction

    task automatic idle();
        wr0_en_i = 0; wr0_addr_i = 0; wr0_data_i = 0;
        wr1_en_i = 0; wr1_addr_i = 0; wr1_data_i = 0;
        busy_set_i = 0; busy_addr_i = 0;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2);
        rd_addr_i = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    // Called at a negedge with inputs set: predict, push, advance one cycle.
    task automatic commit();
        logic [EW-1:0] e;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          b;
        e = '0;
        for (int k = 0; k < RD; k++) begin
            a = rd_addr_i[k*AW +: AW];
            if (int'(a) == PC)                       d = pc_i;
            else if (wr1_en_i && wr1_addr_i == a)    d = wr1_data_i;
            else if (wr0_en_i && wr0_addr_i == a)    d = wr0_data_i;
            else                                     d = m_reg[a];
            if (int'(a) == PC)                       b = 1'b0;
            else if (busy_set_i && busy_addr_i == a) b = 1'b1;
            else if (wr1_en_i && wr1_addr_i == a)    b = 1'b0;
            else                                     b = m_busy[a];
            e[k*DW +: DW] = d;
            e[RD*DW + k]  = b;
        end
        exp_q.push_back(e);
        if (wr0_en_i && int'(wr0_addr_i) != PC) m_reg[wr0_addr_i] = wr0_data_i;
        if (wr1_en_i && int'(wr1_addr_i) != PC) m_reg[wr1_addr_i] = wr1_data_i;
        if (wr1_en_i)   m_busy[wr1_addr_i]  = 1'b0;
        if (busy_set_i) m_busy[busy_addr_i] = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if (rd_data_o !== '0 || rd_busy_o !== '0) begin
            n_err++;
            $display("FAIL %s got data=%h busy=%b exp data=0 busy=0", name, rd_data_o, rd_busy_o);
        end
    endtask

    // monitor: one registered result per committed cycle
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if ({rd_busy_o, rd_data_o} !== e) begin
                    n_err++;
                    $display("FAIL read_ports t=%0t got busy=%b data=%h exp busy=%b data=%h",
                             $time, rd_busy_o, rd_data_o, e[EW-1 -: RD], e[RD*DW-1:0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        int guard;
        idle();
        set_rd(0, 0, 0);
        pc_i = 0;
        reset_ni = 1'b1;
        #1 reset_ni = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        #1 check_zero("reset_outputs");
        @(negedge clk_i);
        reset_ni = 1'b1;

        // reset contents
        set_rd(0, 1, 5); commit();

        // wr0 bypass then array
        wr0_en_i = 1; wr0_addr_i = 3; wr0_data_i = 32'hDEAD_BEEF;
        set_rd(3, 3, 0); commit();
        idle(); commit();

        // dual write same address, wr1 wins
        wr0_en_i = 1; wr0_addr_i = 7; wr0_data_i = 32'h11;
        wr1_en_i = 1; wr1_addr_i = 7; wr1_data_i = 32'h22;
        set_rd(7, 7, 7); commit();
        idle(); commit();

        // scoreboard
        busy_set_i = 1; busy_addr_i = 4; set_rd(0, 0, 4); commit();
        idle(); set_rd(4, 4, 4); commit();
        wr1_en_i = 1; wr1_addr_i = 4; wr1_data_i = 32'h44; commit();
        idle(); commit();
        busy_set_i = 1; busy_addr_i = 4;
        wr1_en_i = 1; wr1_addr_i = 4; wr1_data_i = 32'h45; commit();
        idle(); commit();

        // PC alias, writes to PC dropped
        pc_i = 32'h100; set_rd(PC, 0, 0); commit();
        wr0_en_i = 1; wr0_addr_i = 4'(PC); wr0_data_i = 32'h55;
        pc_i = 32'h104; set_rd(PC, PC, 1); commit();
        idle(); commit();

        // random traffic
        for (int n = 0; n < 300; n++) begin
            set_rd($urandom_range(0, NR-1), $urandom_range(0, NR-1), $urandom_range(0, NR-1));
            pc_i        = $urandom;
            wr0_en_i    = 1'($urandom_range(0, 1));
            wr0_addr_i  = 4'($urandom_range(0, NR-1));
            wr0_data_i  = $urandom;
            wr1_en_i    = 1'($urandom_range(0, 1));
            wr1_addr_i  = 4'($urandom_range(0, NR-1));
            wr1_data_i  = $urandom;
            busy_set_i  = 1'($urandom_range(0, 1));
            busy_addr_i = 4'($urandom_range(0, NR-1));
            commit();
        end

        // mid-operation reset
        idle();
        wr0_en_i = 1; wr0_addr_i = 2; wr0_data_i = 32'h99;
        set_rd(2, 1, 2); commit();
        #2 reset_ni = 1'b0;
        #1 check_zero("async_reset");
        model_reset();
        @(posedge clk_i);
        #1 check_zero("reset_held");
        @(negedge clk_i);
        idle();
        reset_ni = 1'b1;
        set_rd(2, 2, 3); commit();
        commit();

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
